cache_ctrl_nway: RTL and testbench

CACHE_CTRL_NWAY -- requirements
Module: cache_ctrl_nway

---
 rtl/cache_ctrl_nway.sv | 159 +++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - N-way cache controller FSM: hit service, dirty writeback, line fill, write-through
module cache_ctrl_nway #(
    parameter int WAYS          = 2,
    parameter int BEATS         = 4,
    parameter int WRITE_THROUGH = 0,
    localparam int BW           = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [3:0]      mem_byte_enable,
    output logic            mem_resp,
    input  logic            hit,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] victim_way,
    input  logic            victim_dirty,
    output logic            array_read,
    output logic [WAYS-1:0] way_load,
    output logic            dirty_set,
    output logic            dirty_clr,
    output logic            lru_load,
    output logic            datawritemux_sel,
    output logic            pmemaddrmux_sel,
    output logic            fill_load,
    output logic [BW-1:0]   beat,
    output logic            pmem_read,
    output logic            pmem_write,
    input  logic            pmem_resp
);

    typedef enum logic [2:0] {
        S_CHECK   = 3'd0,
        S_WB      = 3'd1,
        S_FILL    = 3'd2,
        S_INSTALL = 3'd3,
        S_WT      = 3'd4
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [WAYS-1:0] vway_q, vway_d;

    logic req;
    logic wr_data;

    // Both read and write asserted is treated as a write.
    assign req     = mem_read | mem_write;
    assign wr_data = mem_write & (mem_byte_enable != 4'b0000);

    // State, beat counter and latched victim way; reset takes effect without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CHECK;
            beat_q  <= '0;
            vway_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vway_q  <= vway_d;
        end
    end

    // Next-state and output decode; reset masks every output back to the idle pattern.
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        vway_d           = vway_q;
        mem_resp         = 1'b0;
        array_read       = 1'b1;
        way_load         = '0;
        dirty_set        = 1'b0;
        dirty_clr        = 1'b0;
        lru_load         = 1'b0;
        datawritemux_sel = 1'b0;
        pmemaddrmux_sel  = 1'b0;
        fill_load        = 1'b0;
        beat             = '0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;

        if (!rst) begin
            case (state_q)
                S_CHECK: begin
                    if (req) begin
                        if (hit) begin
                            lru_load = 1'b1;
                            if (wr_data) begin
                                way_load         = hit_way;
                                datawritemux_sel = 1'b1;
                                if (WRITE_THROUGH != 0) begin
                                    state_d = S_WT;
                                end else begin
                                    mem_resp  = 1'b1;
                                    dirty_set = 1'b1;
                                end
                            end else begin
                                // Reads and empty-mask writes finish at once with no array write.
                                mem_resp = 1'b1;
                            end
                        end else begin
                            vway_d = victim_way;
                            beat_d = '0;
                            if (WRITE_THROUGH == 0 && victim_dirty)
                                state_d = S_WB;
                            else
                                state_d = S_FILL;
                        end
                    end
                end
                S_WB: begin
                    pmem_write      = 1'b1;
                    pmemaddrmux_sel = 1'b1;
                    beat            = beat_q;
                    if (pmem_resp) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = '0;
                            state_d = S_FILL;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    pmem_read = 1'b1;
                    fill_load = pmem_resp;
                    beat      = beat_q;
                    if (pmem_resp) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = '0;
                            state_d = S_INSTALL;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_INSTALL: begin
                    // Write the filled line into the victim way; the retried request then hits.
                    way_load  = vway_q;
                    dirty_clr = 1'b1;
                    state_d   = S_CHECK;
                end
                S_WT: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        mem_resp = 1'b1;
                        state_d  = S_CHECK;
                    end
                end
                default: begin
                    state_d = S_CHECK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed self-checking bench for cache_ctrl_nway
module tb_cache_ctrl_nway;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Write-back instance: WAYS=4, BEATS=4
    logic       mem_read, mem_write, hit, victim_dirty, pmem_resp;
    logic [3:0] be, hit_way, victim_way;
    logic       mem_resp, array_read, dirty_set, dirty_clr, lru_load;
    logic       dws, pms, fill_load, pmem_read, pmem_write;
    logic [3:0] way_load;
    logic [1:0] beat;

    // Write-through instance: WAYS=4, BEATS=1
    logic       w_mem_read, w_mem_write, w_hit, w_victim_dirty, w_pmem_resp;
    logic [3:0] w_be, w_hit_way, w_victim_way;
    logic       w_mem_resp, w_array_read, w_dirty_set, w_dirty_clr, w_lru_load;
    logic       w_dws, w_pms, w_fill_load, w_pmem_read, w_pmem_write;
    logic [3:0] w_way_load;
    logic [0:0] w_beat;

    cache_ctrl_nway #(.WAYS(4), .BEATS(4), .WRITE_THROUGH(0)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(be),
        .mem_resp(mem_resp), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_dirty(victim_dirty),
        .array_read(array_read), .way_load(way_load),
        .dirty_set(dirty_set), .dirty_clr(dirty_clr), .lru_load(lru_load),
        .datawritemux_sel(dws), .pmemaddrmux_sel(pms),
        .fill_load(fill_load), .beat(beat),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    cache_ctrl_nway #(.WAYS(4), .BEATS(1), .WRITE_THROUGH(1)) dut_wt (
        .clk(clk), .rst(rst),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_byte_enable(w_be),
        .mem_resp(w_mem_resp), .hit(w_hit), .hit_way(w_hit_way),
        .victim_way(w_victim_way), .victim_dirty(w_victim_dirty),
        .array_read(w_array_read), .way_load(w_way_load),
        .dirty_set(w_dirty_set), .dirty_clr(w_dirty_clr), .lru_load(w_lru_load),
        .datawritemux_sel(w_dws), .pmemaddrmux_sel(w_pms),
        .fill_load(w_fill_load), .beat(w_beat),
        .pmem_read(w_pmem_read), .pmem_write(w_pmem_write), .pmem_resp(w_pmem_resp)
    );

    logic [15:0] obs, w_obs, exp;

    assign obs   = {mem_resp, array_read, way_load, dirty_set, dirty_clr, lru_load,
                    dws, pms, fill_load, beat, pmem_read, pmem_write};
    assign w_obs = {w_mem_resp, w_array_read, w_way_load, w_dirty_set, w_dirty_clr, w_lru_load,
                    w_dws, w_pms, w_fill_load, 1'b0, w_beat, w_pmem_read, w_pmem_write};

    // Expected output vector; array_read is expected high in every state.
    function automatic logic [15:0] ev(input logic mr, input logic [3:0] wl,
                                       input logic ds, input logic dc, input logic ll,
                                       input logic dw, input logic pm, input logic fl,
                                       input logic [1:0] bt, input logic pr, input logic pw);
        return {mr, 1'b1, wl, ds, dc, ll, dw, pm, fl, bt, pr, pw};
    endfunction

    localparam logic [15:0] IDLE = 16'b0100_0000_0000_0000;

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; be = 4'hF; hit = 0; hit_way = 0;
        victim_way = 0; victim_dirty = 0; pmem_resp = 0;
        w_mem_read = 0; w_mem_write = 0; w_be = 4'hF; w_hit = 0; w_hit_way = 0;
        w_victim_way = 0; w_victim_dirty = 0; w_pmem_resp = 0;
    endtask

    task automatic test_reset();
        mem_read = 1; hit = 1; hit_way = 4'b0001; pmem_resp = 1;
        w_mem_write = 1; w_hit = 1; w_hit_way = 4'b0001;
        #1;
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL reset_wb: got %h want %h", obs, IDLE); end
        total++;
        if (w_obs !== IDLE) begin bad++; $display("FAIL reset_wt: got %h want %h", w_obs, IDLE); end
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1;
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL idle_after_reset: got %h want %h", obs, IDLE); end
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        for (int c = 0; c < 3; c++) begin
            mem_read = 1; hit = 1; hit_way = 4'b0100;
            exp = ev(1, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL read_hit c%0d: got %h want %h", c, obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_write_hit();
        for (int c = 0; c < 4; c++) begin
            hit = 1;
            case (c)
                0: begin mem_write = 1; be = 4'hF; hit_way = 4'b0010;
                         exp = ev(1, 4'b0010, 1, 0, 1, 1, 0, 0, 2'd0, 0, 0); end
                1: begin mem_write = 1; be = 4'h0; hit_way = 4'b0010;
                         exp = ev(1, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0); end
                2: begin mem_read = 1; mem_write = 1; be = 4'b0001; hit_way = 4'b1000;
                         exp = ev(1, 4'b1000, 1, 0, 1, 1, 0, 0, 2'd0, 0, 0); end
                default: begin mem_read = 0; mem_write = 0; hit = 1; exp = IDLE; end
            endcase
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL write_hit c%0d: got %h want %h", c, obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_dirty_miss();
        for (int c = 0; c <= 10; c++) begin
            mem_write = (c == 0 || c == 10); hit = (c == 10);
            hit_way = (c == 10) ? 4'b0010 : 4'b0000; be = 4'hF;
            victim_way = 4'b0010; victim_dirty = 1; pmem_resp = 1;
            if (c == 0)      exp = IDLE;
            else if (c <= 4) exp = ev(0, 4'b0000, 0, 0, 0, 0, 1, 0, 2'(c - 1), 0, 1);
            else if (c <= 8) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'(c - 5), 1, 0);
            else if (c == 9) exp = ev(0, 4'b0010, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0);
            else             exp = ev(1, 4'b0010, 1, 0, 1, 1, 0, 0, 2'd0, 0, 0);
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL dirty_miss c%0d: got %h want %h", c, obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_clean_miss_stall();
        for (int c = 0; c <= 7; c++) begin
            mem_read = 1; hit = (c == 7); hit_way = (c == 7) ? 4'b1000 : 4'b0000;
            victim_way = 4'b1000; victim_dirty = 0; pmem_resp = (c >= 2);
            if (c == 0)      exp = IDLE;
            else if (c == 1) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
            else if (c <= 5) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'(c - 2), 1, 0);
            else if (c == 6) exp = ev(0, 4'b1000, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0);
            else             exp = ev(1, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL clean_miss c%0d: got %h want %h", c, obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_fill();
        for (int c = 0; c <= 3; c++) begin
            mem_read = 1; hit = 0; victim_way = 4'b0001; victim_dirty = 0;
            pmem_resp = (c == 1 || c == 2);
            if (c == 0) exp = IDLE;
            else        exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, (c != 3), 2'(c - 1), 1, 0);
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL pre_reset_fill c%0d: got %h want %h", c, obs, exp); end
            if (c < 3) @(negedge clk);
        end
        hit = 1; hit_way = 4'b0001;
        rst = 1;
        #1;
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL async_reset_fill: got %h want %h", obs, IDLE); end
        @(negedge clk);
        rst = 0; hit = 0; hit_way = 0; victim_way = 4'b0100; pmem_resp = 0;
        // First cycle after release: a miss must be taken from CHECK and the fill start at beat 0.
        for (int c = 0; c <= 6; c++) begin
            pmem_resp = (c >= 1 && c <= 4);
            if (c == 0)      exp = IDLE;
            else if (c <= 4) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'(c - 1), 1, 0);
            else if (c == 5) exp = ev(0, 4'b0100, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0);
            else begin
                hit = 1; hit_way = 4'b0100;
                exp = ev(1, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
            end
            #1;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL post_reset c%0d: got %h want %h", c, obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_write_through();
        for (int c = 0; c <= 4; c++) begin
            w_mem_write = (c == 0); w_hit = (c == 0); w_hit_way = 4'b0001; w_be = 4'hF;
            w_pmem_resp = (c >= 3);
            if (c == 0)      exp = ev(0, 4'b0001, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0);
            else if (c <= 2) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
            else if (c == 3) exp = ev(1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
            else             exp = IDLE;
            #1;
            total++;
            if (w_obs !== exp) begin bad++; $display("FAIL wt_hit c%0d: got %h want %h", c, w_obs, exp); end
            @(negedge clk);
        end
        for (int c = 0; c <= 1; c++) begin
            w_mem_write = (c == 0); w_hit = 1; w_be = 4'h0; w_pmem_resp = 0;
            exp = (c == 0) ? ev(1, 4'b0000, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0) : IDLE;
            #1;
            total++;
            if (w_obs !== exp) begin bad++; $display("FAIL wt_zero_mask c%0d: got %h want %h", c, w_obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_wt_miss_single_beat();
        for (int c = 0; c <= 4; c++) begin
            w_mem_write = 1; w_be = 4'hF; w_hit = (c >= 3); w_hit_way = 4'b0100;
            w_victim_way = 4'b0100; w_victim_dirty = 1; w_pmem_resp = (c == 1 || c == 4);
            if (c == 0)      exp = IDLE;
            else if (c == 1) exp = ev(0, 4'b0000, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0);
            else if (c == 2) exp = ev(0, 4'b0100, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0);
            else if (c == 3) exp = ev(0, 4'b0100, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0);
            else             exp = ev(1, 4'b0000, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
            if (c == 4) begin w_mem_write = 0; w_hit = 0; end
            #1;
            total++;
            if (w_obs !== exp) begin bad++; $display("FAIL wt_miss c%0d: got %h want %h", c, w_obs, exp); end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_clean_miss_stall();
        test_reset_mid_fill();
        test_write_through();
        test_wt_miss_single_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
